// File: rtl/ball_motion_gen_pkg.sv
// Shared constants, state encoding and per-axis bounce helper for the ball
// motion generator and the drawing stage that renders the ball.
package ball_motion_gen_pkg;

    localparam int unsigned H_ACTIVE_DEF     = 640;
    localparam int unsigned V_ACTIVE_DEF     = 480;
    localparam int unsigned RADIUS_DEF       = 20;
    localparam int unsigned SERVE_FRAMES_DEF = 60;

    localparam int unsigned XMIN_DEF = RADIUS_DEF;
    localparam int unsigned XMAX_DEF = H_ACTIVE_DEF - 1 - RADIUS_DEF;
    localparam int unsigned YMIN_DEF = RADIUS_DEF;
    localparam int unsigned YMAX_DEF = V_ACTIVE_DEF - 1 - RADIUS_DEF;

    // Direction bit: 1 moves towards larger coordinates (right / down).
    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } ball_state_e;

    typedef struct packed {
        logic [11:0] pos;
        logic        dir;
        logic        hit;
    } axis_t;

    // One frame of motion on one axis, clamping to the wall and reversing on contact.
    function automatic axis_t axis_move(input logic [11:0] pos,
                                        input logic        dir,
                                        input logic [11:0] step,
                                        input logic [11:0] lo,
                                        input logic [11:0] hi);
        axis_t r;
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (dir == DIR_INC) begin
            if (pos + step > hi) begin
                r.pos = hi;
                r.dir = DIR_DEC;
                r.hit = 1'b1;
            end else begin
                r.pos = pos + step;
            end
        end else begin
            if (pos < lo + step) begin
                r.pos = lo;
                r.dir = DIR_INC;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - step;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ball_motion_gen_if.sv
// Ball state bus published by the motion generator to the drawing stage.
interface ball_motion_gen_if;
    logic [10:0] center_x;
    logic [10:0] center_y;
    logic        hit_x;
    logic        hit_y;

    modport master (output center_x, center_y, hit_x, hit_y);
    modport slave  (input  center_x, center_y, hit_x, hit_y);
endinterface

// File: rtl/ball_motion_gen_vsync_edge.sv
// Frame tick generator: one-cycle pulse on each falling edge of VSYNC.
module vsync_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic VSYNC,
    output logic tick
);

    logic vsync_d_q;

    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vsync_d_q <= 1'b1;
        end else begin
            vsync_d_q <= VSYNC;
        end
    end

    // Combinational so the tick is seen on the same edge that samples the low VSYNC.
    assign tick = vsync_d_q & ~VSYNC;

endmodule

// File: rtl/ball_motion_gen.sv
// Bouncing-ball position generator: serves from centre, then steps once per
// frame, reflecting off the active-area walls and pulsing a hit per axis.
module ball_motion_gen
    import ball_motion_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned RADIUS       = RADIUS_DEF,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        VSYNC,
    input  logic [1:0]  SPEED,
    input  logic        PAUSE,
    output logic [10:0] center_x,
    output logic [10:0] center_y,
    output logic        hit_x,
    output logic        hit_y
);

    localparam logic [11:0] X_MIN = 12'(RADIUS);
    localparam logic [11:0] X_MAX = 12'(H_ACTIVE - 1 - RADIUS);
    localparam logic [11:0] Y_MIN = 12'(RADIUS);
    localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1 - RADIUS);
    localparam logic [11:0] X_CTR = 12'(H_ACTIVE / 2);
    localparam logic [11:0] Y_CTR = 12'(V_ACTIVE / 2);

    localparam int unsigned        CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    logic tick;

    vsync_edge u_vsync_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .VSYNC (VSYNC),
        .tick  (tick)
    );

    ball_state_e      state_q, state_d;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [11:0]      pos_x_q, pos_x_d;
    logic [11:0]      pos_y_q, pos_y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic             hit_x_q, hit_x_d;
    logic             hit_y_q, hit_y_d;

    logic [11:0]      step;
    axis_t            next_x;
    axis_t            next_y;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        hit_x_d     = 1'b0;
        hit_y_d     = 1'b0;

        step   = 12'(SPEED) + 12'd1;
        next_x = axis_move(pos_x_q, dir_x_q, step, X_MIN, X_MAX);
        next_y = axis_move(pos_y_q, dir_y_q, step, Y_MIN, Y_MAX);

        unique case (state_q)
            ST_SERVE: begin
                pos_x_d = X_CTR;
                pos_y_d = Y_CTR;
                if (tick) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = ST_RUN;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (PAUSE) begin
                    state_d = ST_HOLD;
                end else if (tick) begin
                    pos_x_d = next_x.pos;
                    dir_x_d = next_x.dir;
                    hit_x_d = next_x.hit;
                    pos_y_d = next_y.pos;
                    dir_y_d = next_y.dir;
                    hit_y_d = next_y.hit;
                end
            end
            ST_HOLD: begin
                if (!PAUSE) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_SERVE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_SERVE;
            serve_cnt_q <= '0;
            pos_x_q     <= X_CTR;
            pos_y_q     <= Y_CTR;
            dir_x_q     <= DIR_INC;
            dir_y_q     <= DIR_INC;
            hit_x_q     <= 1'b0;
            hit_y_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
        end
    end

    assign center_x = pos_x_q[10:0];
    assign center_y = pos_y_q[10:0];
    assign hit_x    = hit_x_q;
    assign hit_y    = hit_y_q;

endmodule

// File: tb/tb_ball_motion_gen.sv
// Scoreboard bench for ball_motion_gen: a frame-level reference model queues
// the expected ball state per VSYNC fall; a monitor checks every cycle.
module tb_ball_motion_gen;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic       VSYNC = 1'b1;
    logic [1:0] SPEED = 2'd0;
    logic       PAUSE = 1'b0;

    always #5 CLK = ~CLK;

    ball_motion_gen_if bus ();

    ball_motion_gen dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .VSYNC    (VSYNC),
        .SPEED    (SPEED),
        .PAUSE    (PAUSE),
        .center_x (bus.center_x),
        .center_y (bus.center_y),
        .hit_x    (bus.hit_x),
        .hit_y    (bus.hit_y)
    );

    typedef struct {
        int x;
        int y;
        bit hx;
        bit hy;
    } obs_t;

    obs_t exp_q[$];
    obs_t cur;
    obs_t popped;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: ball in abstract integer coordinates, velocity as +/-1.
    int mx, my, mdx, mdy, serve_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic void reset_model();
        mx = 320; my = 240; mdx = 1; mdy = 1; serve_left = 60;
    endfunction

    function automatic obs_t model_tick(input int spd, input bit paused);
        obs_t o;
        int   step;
        o.hx = 1'b0;
        o.hy = 1'b0;
        if (serve_left > 0) begin
            serve_left--;
        end else if (!paused) begin
            step = spd + 1;
            mx += mdx * step;
            my += mdy * step;
            if (mx > 619) begin mx = 619; mdx = -1; o.hx = 1'b1; end
            else if (mx < 20) begin mx = 20; mdx = 1; o.hx = 1'b1; end
            if (my > 459) begin my = 459; mdy = -1; o.hy = 1'b1; end
            else if (my < 20) begin my = 20; mdy = 1; o.hy = 1'b1; end
        end
        o.x = mx;
        o.y = my;
        return o;
    endfunction

    // One VSYNC frame: low for lo cycles, then high for hi cycles.
    task automatic frame(input int lo, input int hi, output obs_t o);
        @(negedge CLK);
        VSYNC = 1'b0;
        exp_q.push_back(model_tick(int'(SPEED), PAUSE));
        @(posedge CLK);
        #1;
        o.x  = int'(bus.center_x);
        o.y  = int'(bus.center_y);
        o.hx = bus.hit_x;
        o.hy = bus.hit_y;
        repeat (lo - 1) @(negedge CLK);
        @(negedge CLK);
        VSYNC = 1'b1;
        repeat (hi - 1) @(negedge CLK);
    endtask

    // Monitor: on a tick cycle compare against the queued frame result,
    // on every other cycle the ball must stay put with no hit pulses.
    bit vs_prev = 1'b1;
    bit tk;

    always @(posedge CLK) begin
        if (!RESET) begin
            vs_prev = 1'b1;
            cur     = '{320, 240, 1'b0, 1'b0};
        end else begin
            tk      = vs_prev && !VSYNC;
            vs_prev = VSYNC;
            #1;
            if (tk) begin
                if (exp_q.size() == 0) begin
                    check("tick_without_expectation", 32'd1, 32'd0);
                end else begin
                    popped = exp_q.pop_front();
                    check("tick_x", 32'(bus.center_x), 32'(popped.x));
                    check("tick_y", 32'(bus.center_y), 32'(popped.y));
                    check("tick_hit_x", 32'(bus.hit_x), 32'(popped.hx));
                    check("tick_hit_y", 32'(bus.hit_y), 32'(popped.hy));
                    cur = popped;
                end
            end else begin
                check("idle_x", 32'(bus.center_x), 32'(cur.x));
                check("idle_y", 32'(bus.center_y), 32'(cur.y));
                check("idle_hits", {30'd0, bus.hit_x, bus.hit_y}, 32'd0);
            end
        end
    end

    obs_t o;

    initial begin
        reset_model();
        repeat (3) @(negedge CLK);
        check("reset_x", 32'(bus.center_x), 32'd320);
        check("reset_y", 32'(bus.center_y), 32'd240);
        check("reset_hits", {30'd0, bus.hit_x, bus.hit_y}, 32'd0);
        RESET = 1'b1;

        // Serve delay at minimum speed: first motion on the 61st frame.
        SPEED = 2'd0;
        for (int i = 1; i <= 61; i++) begin
            frame(1, 3, o);
            if (i == 60) begin
                check("serve_end_x", 32'(o.x), 32'd320);
                check("serve_end_y", 32'(o.y), 32'd240);
            end
            if (i == 61) begin
                check("first_move_x", 32'(o.x), 32'd321);
                check("first_move_y", 32'(o.y), 32'd241);
            end
        end

        // Asynchronous reset mid-run, observed before any clock edge.
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("async_reset_x", 32'(bus.center_x), 32'd320);
        check("async_reset_y", 32'(bus.center_y), 32'd240);
        check("async_reset_hits", {30'd0, bus.hit_x, bus.hit_y}, 32'd0);
        reset_model();
        @(negedge CLK);
        RESET = 1'b1;

        // Full serve again, then fast run into both walls.
        SPEED = 2'd3;
        for (int i = 1; i <= 60; i++) begin
            frame(int'($urandom_range(1, 2)), int'($urandom_range(2, 3)), o);
            if (i == 60) check("reserve_x", 32'(o.x), 32'd320);
        end
        for (int i = 1; i <= 76; i++) begin
            frame(int'($urandom_range(1, 2)), int'($urandom_range(2, 3)), o);
            if (i == 55) begin
                check("bottom_wall_y", 32'(o.y), 32'd459);
                check("bottom_wall_hit", 32'(o.hy), 32'd1);
            end
            if (i == 56) check("after_bottom_y", 32'(o.y), 32'd455);
            if (i == 75) begin
                check("right_wall_x", 32'(o.x), 32'd619);
                check("right_wall_hit", 32'(o.hx), 32'd1);
            end
            if (i == 76) check("after_right_x", 32'(o.x), 32'd615);
        end

        // Pause for ten frames, then resume.
        PAUSE = 1'b1;
        repeat (10) frame(1, 3, o);
        PAUSE = 1'b0;
        frame(1, 3, o);

        // Long VSYNC low: exactly one tick.
        frame(1000, 3, o);

        // Speed change between ticks.
        SPEED = 2'd0;
        frame(2, 3, o);
        SPEED = 2'd2;
        frame(2, 3, o);

        // Randomised frames with speed changes and pause episodes.
        for (int i = 0; i < 250; i++) begin
            SPEED = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) PAUSE = ~PAUSE;
            frame(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), o);
        end
        PAUSE = 1'b0;

        repeat (5) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_motion_gen.md
BALL_MOTION_GEN -- requirements
Module: ball_motion_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter RADIUS, default 20, ball radius in pixels.
REQ-004 SHALL have parameter SERVE_FRAMES, default 60, frames the ball is held at centre before moving.
REQ-005 SHALL have port CLK  input  1  single system clock; all logic uses the rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port VSYNC  input  1  active-low vertical sync from the drawing stage, synchronous to CLK.
REQ-008 SHALL have port SPEED  input  2  step size per frame, equal to SPEED+1 pixels (1..4).
REQ-009 SHALL have port PAUSE  input  1  level; high freezes motion.
REQ-010 SHALL have port center_x  output  11  ball centre column, registered.
REQ-011 SHALL have port center_y  output  11  ball centre row, registered.
REQ-012 SHALL have port hit_x  output  1  one-cycle pulse on a left/right wall bounce.
REQ-013 SHALL have port hit_y  output  1  one-cycle pulse on a top/bottom wall bounce.

Function
REQ-014 SHALL register VSYNC into vsync_d; frame tick = vsync_d high AND VSYNC low (falling edge), one cycle per frame.
REQ-015 SHALL limit the ball to XMIN=RADIUS, XMAX=H_ACTIVE-1-RADIUS (20..619) and YMIN=RADIUS, YMAX=V_ACTIVE-1-RADIUS (20..459).
REQ-016 SHALL implement states SERVE, RUN and HOLD.
REQ-017 SERVE SHALL hold centre at (H_ACTIVE/2, V_ACTIVE/2) and count ticks; PAUSE is ignored in SERVE.
REQ-018 SERVE SHALL move to RUN on the tick at which the serve counter equals SERVE_FRAMES-1; that tick does not move the ball.
REQ-019 In RUN, PAUSE high SHALL move to HOLD on the next edge; in HOLD, PAUSE low SHALL return to RUN on the next edge.
REQ-020 HOLD SHALL ignore ticks; position and direction stay unchanged.
REQ-021 On a RUN tick, step = SPEED+1, sampled that cycle; each axis moves by ±step according to its direction bit.
REQ-022 When moving right and x+step > XMAX, x SHALL become XMAX, dir_x becomes left and hit_x pulses; the left wall is symmetric (x < XMIN+step -> XMIN).
REQ-023 The Y axis SHALL follow the same rule using YMIN/YMAX, dir_y and hit_y.
REQ-024 Both hit pulses SHALL fire in the same cycle when both axes bounce on one tick.
REQ-025 Position updates SHALL take effect at the clock edge that detects the tick (zero-cycle latency from the sampled edge); hit pulses coincide with that update.
REQ-026 Arithmetic SHALL be 12-bit unsigned internally, so the comparison has no wrap-around; outputs are 11 bits.
REQ-027 VSYNC held low SHALL produce exactly one tick.

Reset
REQ-028 RESET low SHALL asynchronously set center_x=320, center_y=240, dir right/down, hit_x=hit_y=0, state SERVE, serve counter 0 and vsync_d=1.
REQ-029 Reset asserted mid-RUN SHALL return to SERVE and restart the full serve delay after release.

Structure
REQ-030 A shared package/include SHALL hold H_ACTIVE, V_ACTIVE, RADIUS, SERVE_FRAMES, the derived limits and the state encoding, shared with the drawing stage.
REQ-031 The VSYNC falling-edge detector SHALL be one sub-module, vsync_edge (CLK, RESET, VSYNC -> tick).
REQ-032 Total RTL SHALL be 120-400 lines.

Verification
REQ-033 Reset, SPEED=0, 61 VSYNC falls -> centre stays (320,240) through tick 60; tick 61 gives (321,241).
REQ-034 SPEED=3 after serve -> run tick 55 gives y=459 with hit_y; run tick 75 gives x=619 with hit_x; the next ticks give y=455 and x=615.
REQ-035 PAUSE high for 10 frames mid-run -> centre constant and no hits; the first tick after release moves the ball by one step.
REQ-036 VSYNC held low 1000 cycles -> exactly one position update.
REQ-037 RESET pulsed low mid-run -> outputs are (320,240) and hits 0 immediately (asynchronously); 60 further ticks give no motion.
REQ-038 SPEED changed 0->2 between ticks -> the next tick steps 3 pixels.
